// File: rtl/instq_reg.sv
// Instruction register fed by a DEPTH-entry prefetch queue.
// The bus side pushes instruction words and the control unit pops them into the IR.
// The IR's opcode field is always visible; the operand field is gated onto the address bus.
module instq_reg #(
  parameter int DW    = 8,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [DW-1:0]              busin,
  input  logic                       wa,
  input  logic                       ld,
  input  logic                       flush,
  input  logic                       oa,
  output logic [OPW-1:0]             opout,
  output logic [DW-OPW-1:0]          addrout,
  output logic                       ir_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic [DW-1:0] ir;
  logic          irv;
  logic          ovf_q;

  logic          do_pop;
  logic          do_push;
  logic          ovf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Pop frees a slot on the same edge, so a full queue still accepts a push
  // when the head is being popped. Neither happens while clr or flush is active.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovf_set = 1'b0;
    if (!clr && !flush) begin
      do_pop  = ld & ~empty;
      do_push = wa & (~full | do_pop);
      ovf_set = wa & full & ~do_pop;
    end
  end

  // Queue storage: data only, no reset needed since occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= busin;
  end

  // Pointers, occupancy, IR and status flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ir      <= '0;
      irv     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      irv     <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) begin
        rptr <= rptr + AW'(1);
        ir   <= mem[rptr];
        irv  <= 1'b1;
      end else if (ld) begin
        irv  <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count    = count_q;
  assign ir_valid = irv;
  assign ovf      = ovf_q;
  assign opout    = ir[DW-1:DW-OPW];
  assign addrout  = oa ? ir[DW-OPW-1:0] : '0;

endmodule

// File: tb/tb_instq_reg.sv
// Bench for instq_reg: directed scenarios followed by randomized traffic
// compared against a queue-based reference model.
module tb_instq_reg;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] busin = 8'h00;
  logic       wa = 1'b0;
  logic       ld = 1'b0;
  logic       flush = 1'b0;
  logic       oa = 1'b0;
  logic [3:0] opout;
  logic [3:0] addrout;
  logic       ir_valid;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  instq_reg #(.DW(8), .OPW(4), .DEPTH(4)) dut (
    .clk(clk), .clr(clr), .busin(busin), .wa(wa), .ld(ld), .flush(flush),
    .oa(oa), .opout(opout), .addrout(addrout), .ir_valid(ir_valid),
    .count(count), .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: pop first, then push if room remains.
  logic [7:0] mq[$];
  logic [7:0] mir = 8'h00;
  logic       mirv = 1'b0;
  logic       movf = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      mq.delete();
      mir = 8'h00; mirv = 1'b0; movf = 1'b0;
    end else if (flush) begin
      mq.delete();
      mirv = 1'b0;
    end else begin
      if (ld) begin
        if (mq.size() > 0) begin
          mir = mq.pop_front();
          mirv = 1'b1;
        end else begin
          mirv = 1'b0;
        end
      end
      if (wa) begin
        if (mq.size() < 4) mq.push_back(busin);
        else movf = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa = 0; ld = 0; flush = 0; clr = 0;
  endtask

  task automatic test_reset();
    clr = 1; wa = 1; busin = 8'hFF; oa = 1;
    cyc(); cyc();
    idle();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_irv got %b exp 0", ir_valid); end
    checks++; if (opout !== 4'h0) begin errors++; $display("FAIL reset_opout got %h exp 0", opout); end
    checks++; if (addrout !== 4'h0) begin errors++; $display("FAIL reset_addrout got %h exp 0", addrout); end
  endtask

  task automatic test_basic();
    wa = 1; busin = 8'h3A; cyc();
    busin = 8'h51; cyc();
    wa = 0; ld = 1; oa = 1; cyc();
    checks++; if ({opout, addrout} !== 8'h3A) begin errors++; $display("FAIL basic_pop1 got %h%h exp 3A", opout, addrout); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_irv got %b exp 1", ir_valid); end
    cyc();
    checks++; if ({opout, addrout} !== 8'h51) begin errors++; $display("FAIL basic_pop2 got %h%h exp 51", opout, addrout); end
    ld = 0; oa = 0; #1;
    checks++; if (addrout !== 4'h0) begin errors++; $display("FAIL basic_oa0 got %h exp 0", addrout); end
    checks++; if (opout !== 4'h5) begin errors++; $display("FAIL basic_opout_hold got %h exp 5", opout); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    logic [7:0] w [4];
    w[0] = 8'h10; w[1] = 8'h21; w[2] = 8'h32; w[3] = 8'h43;
    wa = 1;
    for (int i = 0; i < 4; i++) begin busin = w[i]; cyc(); end
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_full got full=%b count=%0d exp 1/4", full, count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf); end
    busin = 8'hFF; cyc();
    wa = 0;
    checks++; if (ovf !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_set got ovf=%b count=%0d exp 1/4", ovf, count); end
    ld = 1; oa = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if ({opout, addrout} !== w[i]) begin errors++; $display("FAIL ovf_pop%0d got %h%h exp %h", i, opout, addrout, w[i]); end
    end
    ld = 0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_bubble();
    ld = 1; cyc();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL bubble_irv got %b exp 0", ir_valid); end
    checks++; if (opout !== 4'h4) begin errors++; $display("FAIL bubble_opout got %h exp 4", opout); end
    wa = 1; busin = 8'h66; cyc();
    idle();
    checks++; if (count !== 3'd1 || ir_valid !== 1'b0) begin errors++; $display("FAIL bubble_wald got count=%0d irv=%b exp 1/0", count, ir_valid); end
    checks++; if (opout !== 4'h4) begin errors++; $display("FAIL bubble_nobypass got %h exp 4", opout); end
  endtask

  task automatic test_full_concurrency();
    logic [7:0] exp_ord [4];
    clr = 1; cyc(); clr = 0;
    wa = 1;
    for (int i = 0; i < 4; i++) begin busin = 8'h60 + 8'(i); cyc(); end
    busin = 8'h54; ld = 1; oa = 1; cyc();
    wa = 0; ld = 0;
    checks++; if (count !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL fullcc got count=%0d ovf=%b exp 4/0", count, ovf); end
    checks++; if ({opout, addrout} !== 8'h60) begin errors++; $display("FAIL fullcc_ir got %h%h exp 60", opout, addrout); end
    exp_ord[0] = 8'h61; exp_ord[1] = 8'h62; exp_ord[2] = 8'h63; exp_ord[3] = 8'h54;
    ld = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if ({opout, addrout} !== exp_ord[i]) begin errors++; $display("FAIL fullcc_pop%0d got %h%h exp %h", i, opout, addrout, exp_ord[i]); end
    end
    ld = 0;
  endtask

  task automatic test_flush_clr();
    wa = 1;
    for (int i = 0; i < 4; i++) begin busin = 8'h70 + 8'(i); cyc(); end
    wa = 0; ld = 1; cyc(); ld = 0;
    checks++; if (count !== 3'd3 || ir_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got count=%0d irv=%b exp 3/1", count, ir_valid); end
    flush = 1; wa = 1; ld = 1; busin = 8'h99; cyc();
    idle();
    checks++; if (count !== 3'd0 || empty !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("FAIL flush_state got count=%0d empty=%b irv=%b exp 0/1/0", count, empty, ir_valid); end
    checks++; if (opout !== 4'h7) begin errors++; $display("FAIL flush_ir_kept got %h exp 7", opout); end
    wa = 1; busin = 8'h80; cyc(); busin = 8'h81; cyc(); wa = 0;
    ld = 1; oa = 1; cyc(); ld = 0;
    checks++; if ({opout, addrout} !== 8'h80) begin errors++; $display("FAIL flush_lost got %h%h exp 80", opout, addrout); end
    clr = 1; wa = 1; ld = 1; flush = 1; cyc();
    idle();
    checks++; if (count !== 3'd0 || ir_valid !== 1'b0 || ovf !== 1'b0 || {opout, addrout} !== 8'h00) begin
      errors++; $display("FAIL clr_mid got count=%0d irv=%b ovf=%b ir=%h%h exp 0/0/0/00", count, ir_valid, ovf, opout, addrout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wa    = ($urandom_range(0, 99) < 55);
      ld    = ($urandom_range(0, 99) < 45);
      flush = ($urandom_range(0, 99) < 4);
      clr   = ($urandom_range(0, 99) < 2);
      oa    = $urandom_range(0, 1);
      busin = 8'($urandom);
      cyc();
      checks++;
      if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 4) ||
          ovf !== movf || ir_valid !== mirv || opout !== mir[7:4] ||
          addrout !== (oa ? mir[3:0] : 4'h0)) begin
        errors++;
        $display("FAIL rand_%0d got cnt=%0d e=%b f=%b ovf=%b irv=%b op=%h ad=%h exp cnt=%0d ovf=%b irv=%b ir=%h oa=%b",
                 i, count, empty, full, ovf, ir_valid, opout, addrout, mq.size(), movf, mirv, mir, oa);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_bubble();
    test_full_concurrency();
    test_flush_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
